// File: rtl/la_chk_pkg.sv
// ----------------------------------------------------------------------------
// la_chk_pkg
//   Shared constants for the logic-analyzer checkpoint bridge. It holds the
//   bit positions of the firmware-facing fields on la_data_in/la_data_out and
//   the display FSM state encoding.
//   Ports: none (package only).
// ----------------------------------------------------------------------------
package la_chk_pkg;

    // la_data_in fields (firmware -> block)
    localparam int REQ_BIT   = 16;
    localparam int FLUSH_BIT = 17;
    localparam int EN_BIT    = 18;

    // la_data_out fields (block -> firmware)
    localparam int ACK_BIT   = 16;
    localparam int LVL_LSB   = 17;
    localparam int LVL_W     = 3;
    localparam int OVF_BIT   = 20;
    localparam int BUSY_BIT  = 21;

    // Display FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/la_chk_fifo.sv
// ----------------------------------------------------------------------------
// la_chk_fifo
//   Synchronous show-ahead FIFO for checkpoint values. Push and pop in the
//   same cycle are both honoured; a push into a full FIFO succeeds when a pop
//   frees the slot in the same cycle. Flush empties the FIFO and discards any
//   same-cycle push. The level saturates at DEPTH and pointers wrap mod DEPTH.
//   Ports:
//     clk_i, rst_i   clock, asynchronous active-high reset
//     push_i/data_i  write request and value
//     pop_i          read request (ignored while empty)
//     flush_i        synchronous clear
//     head_o         oldest entry (valid while !empty_o)
//     full_o/empty_o status flags
//     level_o        number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module la_chk_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;

    logic do_pop, do_push;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // ---- pointer / level stage ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ---- storage stage (data only, no reset) ----
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/la_checkpoint_bridge.sv
// ----------------------------------------------------------------------------
// la_checkpoint_bridge
//   Drives the checkpoint pads from firmware writes over the logic analyzer.
//   Firmware posts a value with a request toggle; the value is queued and each
//   value is shown on chk_out for at least HOLD_CYCLES clocks so an external
//   monitor polling for equality cannot miss it.
//   Ports:
//     wb_clk_i     clock
//     wb_rst_i     asynchronous active-high reset
//     la_data_in   [15:0] value, [16] req toggle, [17] flush, [18] pad enable
//     la_oenb      active-low validity per la_data_in bit
//     la_data_out  [16] ack toggle, [19:17] level, [20] overflow, [21] busy
//     chk_out      checkpoint value to pads
//     chk_oeb      pad output enable, active-low
// ----------------------------------------------------------------------------
module la_checkpoint_bridge
    import la_chk_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 4,
    parameter int               HOLD_CYCLES = 1024,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [63:0]      la_data_in,
    input  logic [63:0]      la_oenb,
    output logic [63:0]      la_data_out,
    output logic [WIDTH-1:0] chk_out,
    output logic [WIDTH-1:0] chk_oeb
);

    localparam int CW = $clog2(HOLD_CYCLES+1);
    localparam int LW = $clog2(DEPTH+1);

    // Request synchroniser / capture
    logic             r_req_q, r_req_d_q, r_gate_q;
    logic [WIDTH-1:0] r_val_q;

    // Status and display registers
    logic             ack_q, ack_d;
    logic             ovf_q, ovf_d;
    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] chk_q, chk_d;
    logic [WIDTH-1:0] oeb_q;

    logic             edge_w, flush_w, pop_w;
    logic [WIDTH-1:0] head_w;
    logic             full_w, empty_w;
    logic [LW-1:0]    level_w;

    logic unused_la;
    assign unused_la = ^{la_data_in[63:EN_BIT+1], la_oenb[63:EN_BIT+1], la_oenb[REQ_BIT-1:0]};

    // The gate is captured with the toggle, so a toggle made while its bit is
    // masked is consumed silently and never produces a later edge.
    assign edge_w  = (r_req_q ^ r_req_d_q) & r_gate_q;
    assign flush_w = la_data_in[FLUSH_BIT] & ~la_oenb[FLUSH_BIT];

    la_chk_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (edge_w),
        .data_i  (r_val_q),
        .pop_i   (pop_w),
        .flush_i (flush_w),
        .head_o  (head_w),
        .full_o  (full_w),
        .empty_o (empty_w),
        .level_o (level_w)
    );

    // Ack answers every valid edge, accepted or dropped, so firmware never
    // waits on a full queue. A drop happens only when no pop frees a slot.
    always_comb begin
        ack_d = ack_q ^ edge_w;
        if (flush_w) ovf_d = 1'b0;
        else         ovf_d = ovf_q | (edge_w & full_w & ~pop_w);
    end

    // Display FSM: a value is popped only once the previous one has been held
    // for HOLD_CYCLES cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        pop_w   = 1'b0;
        if (flush_w) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            chk_d   = RESET_VAL;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty_w) begin
                        pop_w   = 1'b1;
                        chk_d   = head_w;
                        cnt_d   = CW'(HOLD_CYCLES - 1);
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (!empty_w) begin
                        pop_w = 1'b1;
                        chk_d = head_w;
                        cnt_d = CW'(HOLD_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // ---- capture stage: LA inputs registered ----
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_req_q   <= 1'b0;
            r_req_d_q <= 1'b0;
            r_gate_q  <= 1'b0;
            r_val_q   <= '0;
            oeb_q     <= '1;
        end else begin
            r_req_q   <= la_data_in[REQ_BIT];
            r_req_d_q <= r_req_q;
            r_gate_q  <= ~la_oenb[REQ_BIT];
            r_val_q   <= la_data_in[WIDTH-1:0];
            oeb_q     <= {WIDTH{~(la_data_in[EN_BIT] & ~la_oenb[EN_BIT])}};
        end
    end

    // ---- control / display stage ----
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            chk_q   <= RESET_VAL;
        end else begin
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
        end
    end

    always_comb begin
        la_data_out                     = '0;
        la_data_out[ACK_BIT]            = ack_q;
        la_data_out[LVL_LSB +: LVL_W]   = LVL_W'(level_w);
        la_data_out[OVF_BIT]            = ovf_q;
        la_data_out[BUSY_BIT]           = (state_q == ST_HOLD);
    end

    assign chk_out = chk_q;
    assign chk_oeb = oeb_q;

endmodule
